// File: rtl/mc_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// mc_ctrl_sequencer
//
// Multicycle control sequencer for the MIPS54 datapath. A Moore FSM walks each
// instruction through FETCH / DECODE / EXEC / MEM / MDWAIT / WB and drives the
// datapath strobes plus the one-hot selects of the downstream 8-way operand and
// write-back muxes. Those selects are exactly-one-hot in every cycle, including
// the reset cycle. Retired instructions are counted.
//
// Optional feature: define MCSEQ_WDOG_EN to add a watchdog on MDWAIT. When it
// trips, it raises the sticky oFault, abandons the instruction without
// write-back or retire, and returns to FETCH. Without the macro oFault is
// tied to 0.
//
// Parameters
//   SEL_WIDTH   width of every one-hot select (at least 4, bit3 = const 4)
//   CNT_WIDTH   width of the retired-instruction counter
//   WDOG_LIMIT  MDWAIT cycles allowed before the watchdog trips
//
// Ports
//   iClk          clock, rising edge
//   iRst_n        synchronous reset, active-low
//   iOpClass      instruction class, sampled in DECODE
//                 (0 ALU_R, 1 ALU_I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JUMP,
//                  6 MULDIV, 7 reserved)
//   iWbSel        decoder's one-hot write-back source, sampled in DECODE
//   iAluBSel      decoder's one-hot ALU-B source, sampled in DECODE
//   iBranchTaken  branch outcome, valid in EXEC
//   iMemBusy      memory not ready; holds FETCH and MEM
//   iMdDone       mul/div completion pulse
//   oPcWrite      PC load strobe
//   oIrWrite      IR load strobe
//   oMemRead      memory read request
//   oMemWrite     memory write request
//   oRegWrite     register file write strobe
//   oMdStart      mul/div start pulse
//   oWbSel        one-hot write-back mux select
//   oAluBSel      one-hot ALU-B mux select
//   oSelErr       sticky: decoder supplied a non-one-hot select
//   oRetireCnt    retired-instruction count (wraps)
//   oFault        sticky watchdog fault
// -----------------------------------------------------------------------------
module mc_ctrl_sequencer #(
  parameter int SEL_WIDTH  = 8,
  parameter int CNT_WIDTH  = 32,
  parameter int WDOG_LIMIT = 64
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic [2:0]           iOpClass,
  input  logic [SEL_WIDTH-1:0] iWbSel,
  input  logic [SEL_WIDTH-1:0] iAluBSel,
  input  logic                 iBranchTaken,
  input  logic                 iMemBusy,
  input  logic                 iMdDone,
  output logic                 oPcWrite,
  output logic                 oIrWrite,
  output logic                 oMemRead,
  output logic                 oMemWrite,
  output logic                 oRegWrite,
  output logic                 oMdStart,
  output logic [SEL_WIDTH-1:0] oWbSel,
  output logic [SEL_WIDTH-1:0] oAluBSel,
  output logic                 oSelErr,
  output logic [CNT_WIDTH-1:0] oRetireCnt,
  output logic                 oFault
);

  // Elaboration-time sanity checks on the configuration.
  if (SEL_WIDTH < 4) begin : gSelWidthCheck
    $error("mc_ctrl_sequencer: SEL_WIDTH must be at least 4");
  end
  if (WDOG_LIMIT < 1) begin : gWdogLimitCheck
    $error("mc_ctrl_sequencer: WDOG_LIMIT must be at least 1");
  end

  // The state register uses one-hot encoding.
  typedef enum logic [6:0] {
    S_IDLE   = 7'b0000001,
    S_FETCH  = 7'b0000010,
    S_DECODE = 7'b0000100,
    S_EXEC   = 7'b0001000,
    S_MEM    = 7'b0010000,
    S_MDWAIT = 7'b0100000,
    S_WB     = 7'b1000000
  } state_e;

  localparam logic [2:0] OP_ALU_R  = 3'd0;
  localparam logic [2:0] OP_ALU_I  = 3'd1;
  localparam logic [2:0] OP_LOAD   = 3'd2;
  localparam logic [2:0] OP_STORE  = 3'd3;
  localparam logic [2:0] OP_BRANCH = 3'd4;
  localparam logic [2:0] OP_JUMP   = 3'd5;
  localparam logic [2:0] OP_MULDIV = 3'd6;

  localparam logic [SEL_WIDTH-1:0] SEL_DEF    = SEL_WIDTH'(1);
  localparam logic [SEL_WIDTH-1:0] SEL_CONST4 = SEL_WIDTH'(8);

  state_e               state_q, state_d;
  logic [2:0]           opClass_q, opClass_d;
  logic [SEL_WIDTH-1:0] wbSel_q, wbSel_d;
  logic [SEL_WIDTH-1:0] aluBSel_q, aluBSel_d;
  logic                 selErr_q, selErr_d;
  logic [CNT_WIDTH-1:0] retireCnt_q, retireCnt_d;

  logic                 retire;
  logic                 pcWrite, irWrite, memRead, memWrite, regWrite, mdStart;
  logic [SEL_WIDTH-1:0] wbSelRaw, aluBSelRaw;

`ifdef MCSEQ_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);
  logic [WDOG_W-1:0] wdogCnt_q, wdogCnt_d;
  logic              fault_q, fault_d;
`endif

  // Next-state and Moore output decode. Selects default to bit0 so that an
  // all-zero or multi-hot value never reaches the downstream muxes.
  always_comb begin
    state_d    = state_q;
    opClass_d  = opClass_q;
    wbSel_d    = wbSel_q;
    aluBSel_d  = aluBSel_q;
    selErr_d   = selErr_q;
    retire     = 1'b0;
    pcWrite    = 1'b0;
    irWrite    = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    regWrite   = 1'b0;
    mdStart    = 1'b0;
    wbSelRaw   = SEL_DEF;
    aluBSelRaw = SEL_DEF;
`ifdef MCSEQ_WDOG_EN
    wdogCnt_d  = '0;
    fault_d    = fault_q;
`endif

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        memRead    = 1'b1;
        aluBSelRaw = SEL_CONST4;
        if (!iMemBusy) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          state_d = S_DECODE;
        end
      end

      // Bad decoder selects are replaced with bit0 so that the
      // one-hot guarantee holds even when the decoder misbehaves.
      S_DECODE: begin
        opClass_d = iOpClass;
        wbSel_d   = $onehot(iWbSel)   ? iWbSel   : SEL_DEF;
        aluBSel_d = $onehot(iAluBSel) ? iAluBSel : SEL_DEF;
        if (!$onehot(iWbSel) || !$onehot(iAluBSel)) begin
          selErr_d = 1'b1;
        end
        state_d = S_EXEC;
      end

      S_EXEC: begin
        aluBSelRaw = aluBSel_q;
        case (opClass_q)
          OP_ALU_R, OP_ALU_I: state_d = S_WB;
          OP_LOAD, OP_STORE:  state_d = S_MEM;
          OP_BRANCH: begin
            pcWrite = iBranchTaken;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OP_JUMP: begin
            pcWrite = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OP_MULDIV: begin
            mdStart = 1'b1;
            state_d = S_MDWAIT;
          end
          default: begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end

      // Only LOAD and STORE reach this state, so any non-STORE is a LOAD.
      S_MEM: begin
        if (opClass_q == OP_STORE) begin
          memWrite = 1'b1;
        end else begin
          memRead = 1'b1;
        end
        if (!iMemBusy) begin
          if (opClass_q == OP_STORE) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end

      // A completion on the limit cycle takes priority over the watchdog.
      S_MDWAIT: begin
`ifdef MCSEQ_WDOG_EN
        wdogCnt_d = wdogCnt_q + WDOG_W'(1);
        if (iMdDone) begin
          state_d = S_WB;
        end else if (wdogCnt_q == WDOG_W'(WDOG_LIMIT - 1)) begin
          fault_d = 1'b1;
          state_d = S_FETCH;
        end
`else
        if (iMdDone) begin
          state_d = S_WB;
        end
`endif
      end

      S_WB: begin
        regWrite = 1'b1;
        wbSelRaw = wbSel_q;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    retireCnt_d = retire ? retireCnt_q + CNT_WIDTH'(1) : retireCnt_q;
  end

  // State, latched decode fields, the sticky error flag, and the retire counter.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q     <= S_IDLE;
      opClass_q   <= '0;
      wbSel_q     <= SEL_DEF;
      aluBSel_q   <= SEL_DEF;
      selErr_q    <= 1'b0;
      retireCnt_q <= '0;
    end else begin
      state_q     <= state_d;
      opClass_q   <= opClass_d;
      wbSel_q     <= wbSel_d;
      aluBSel_q   <= aluBSel_d;
      selErr_q    <= selErr_d;
      retireCnt_q <= retireCnt_d;
    end
  end

`ifdef MCSEQ_WDOG_EN
  // The watchdog counter runs only while in MDWAIT. The fault flag stays set
  // until the next reset.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      wdogCnt_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      wdogCnt_q <= wdogCnt_d;
      fault_q   <= fault_d;
    end
  end

  assign oFault = fault_q;
`else
  assign oFault = 1'b0;
`endif

  // While reset is asserted, the strobes are masked and the selects are
  // forced to bit0. This prevents an aborted instruction from issuing a write
  // in the reset cycle.
  assign oPcWrite   = pcWrite  & iRst_n;
  assign oIrWrite   = irWrite  & iRst_n;
  assign oMemRead   = memRead  & iRst_n;
  assign oMemWrite  = memWrite & iRst_n;
  assign oRegWrite  = regWrite & iRst_n;
  assign oMdStart   = mdStart  & iRst_n;
  assign oWbSel     = iRst_n ? wbSelRaw   : SEL_DEF;
  assign oAluBSel   = iRst_n ? aluBSelRaw : SEL_DEF;
  assign oSelErr    = selErr_q;
  assign oRetireCnt = retireCnt_q;

endmodule

// File: tb/tb_mc_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl_sequencer
//
// Drives the sequencer one cycle at a time from a list of records. Each record
// holds the inputs for that cycle and the outputs expected in that cycle. A
// directed table covers reset and the first ALU instruction. The remaining
// records come from an instruction-level model that expands an instruction
// (class, selects, stall counts) into its expected cycle list. A narrow
// retire counter is used so that wrap-around is exercised.
// -----------------------------------------------------------------------------
module tb_mc_ctrl_sequencer;

  localparam int SW = 8;
  localparam int CW = 4;
  localparam int WL = 4;

  logic          iClk = 1'b0;
  logic          iRst_n;
  logic [2:0]    iOpClass;
  logic [SW-1:0] iWbSel, iAluBSel;
  logic          iBranchTaken, iMemBusy, iMdDone;
  logic          oPcWrite, oIrWrite, oMemRead, oMemWrite, oRegWrite, oMdStart;
  logic [SW-1:0] oWbSel, oAluBSel;
  logic          oSelErr, oFault;
  logic [CW-1:0] oRetireCnt;

  mc_ctrl_sequencer #(.SEL_WIDTH(SW), .CNT_WIDTH(CW), .WDOG_LIMIT(WL)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iOpClass(iOpClass), .iWbSel(iWbSel),
    .iAluBSel(iAluBSel), .iBranchTaken(iBranchTaken), .iMemBusy(iMemBusy),
    .iMdDone(iMdDone), .oPcWrite(oPcWrite), .oIrWrite(oIrWrite),
    .oMemRead(oMemRead), .oMemWrite(oMemWrite), .oRegWrite(oRegWrite),
    .oMdStart(oMdStart), .oWbSel(oWbSel), .oAluBSel(oAluBSel),
    .oSelErr(oSelErr), .oRetireCnt(oRetireCnt), .oFault(oFault)
  );

  always #5 iClk = ~iClk;

  // Strobe field order: {pcWrite, irWrite, memRead, memWrite, regWrite, mdStart}
  typedef struct {
    logic          rstN, busy, mdDone, taken;
    logic [2:0]    op;
    logic [SW-1:0] wbIn, aluIn;
    logic [5:0]    strb;
    logic [SW-1:0] wbSel, aluSel;
    logic          selErr, fault;
    int            cnt;
  } vec_t;

  vec_t dirTab[7];
  vec_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  // Instruction-level model state
  int   mCnt = 0;
  logic mSelErr = 1'b0;
  logic mFault = 1'b0;

  function automatic vec_t dv(input logic rstN, input logic busy, input logic [2:0] op,
                              input logic [SW-1:0] wbIn, input logic [SW-1:0] aluIn,
                              input logic [5:0] strb, input logic [SW-1:0] wbSel,
                              input logic [SW-1:0] aluSel, input int cnt);
    vec_t v;
    v.rstN = rstN; v.busy = busy; v.mdDone = 1'b0; v.taken = 1'b0;
    v.op = op; v.wbIn = wbIn; v.aluIn = aluIn;
    v.strb = strb; v.wbSel = wbSel; v.aluSel = aluSel;
    v.selErr = 1'b0; v.fault = 1'b0; v.cnt = cnt;
    return v;
  endfunction

  // Returns a cycle record with random don't-care inputs and quiet expected
  // outputs.
  function automatic vec_t cyc();
    vec_t v;
    v.rstN = 1'b1;
    v.busy = 1'($urandom); v.mdDone = 1'($urandom); v.taken = 1'($urandom);
    v.op = 3'($urandom); v.wbIn = SW'($urandom); v.aluIn = SW'($urandom);
    v.strb = 6'b0; v.wbSel = SW'(1); v.aluSel = SW'(1);
    v.selErr = mSelErr; v.fault = mFault; v.cnt = mCnt;
    return v;
  endfunction

  function automatic logic [SW-1:0] fixSel(input logic [SW-1:0] s);
    return ($countones(s) == 1) ? s : SW'(1);
  endfunction

  // Expands one instruction into its expected cycles. The mdWait argument
  // gives the number of MDWAIT cycles before iMdDone; a negative value means
  // iMdDone never arrives, which lets the watchdog trip.
  function automatic void buildInstr(input int op, input logic [SW-1:0] wbIn,
                                     input logic [SW-1:0] aluIn, input int fBusy,
                                     input int mBusy, input int mdWait, input logic taken);
    vec_t v;
    logic [SW-1:0] effWb, effAlu;
    bit toWb;
    effWb  = fixSel(wbIn);
    effAlu = fixSel(aluIn);
    toWb   = 1'b0;
    for (int i = 0; i < fBusy; i++) begin
      v = cyc(); v.busy = 1'b1; v.strb = 6'b001000; v.aluSel = SW'(8); expQ.push_back(v);
    end
    v = cyc(); v.busy = 1'b0; v.strb = 6'b111000; v.aluSel = SW'(8); expQ.push_back(v);
    v = cyc(); v.op = 3'(op); v.wbIn = wbIn; v.aluIn = aluIn; expQ.push_back(v);
    if (effWb != wbIn || effAlu != aluIn) mSelErr = 1'b1;
    v = cyc(); v.aluSel = effAlu;
    case (op)
      2, 3: begin
        expQ.push_back(v);
        for (int i = 0; i <= mBusy; i++) begin
          v = cyc(); v.busy = (i < mBusy);
          v.strb = (op == 2) ? 6'b001000 : 6'b000100;
          expQ.push_back(v);
        end
        if (op == 3) mCnt++; else toWb = 1'b1;
      end
      4: begin
        v.taken = taken; v.strb = taken ? 6'b100000 : 6'b000000;
        expQ.push_back(v); mCnt++;
      end
      5: begin v.strb = 6'b100000; expQ.push_back(v); mCnt++; end
      6: begin
        v.strb = 6'b000001; expQ.push_back(v);
        if (mdWait < 0) begin
          for (int i = 0; i < WL; i++) begin
            v = cyc(); v.mdDone = 1'b0; expQ.push_back(v);
          end
          mFault = 1'b1;
        end else begin
          for (int i = 0; i < mdWait; i++) begin
            v = cyc(); v.mdDone = 1'b0; expQ.push_back(v);
          end
          v = cyc(); v.mdDone = 1'b1; expQ.push_back(v);
          toWb = 1'b1;
        end
      end
      7: begin expQ.push_back(v); mCnt++; end
      default: begin expQ.push_back(v); toWb = 1'b1; end
    endcase
    if (toWb) begin
      v = cyc(); v.strb = 6'b000010; v.wbSel = effWb; expQ.push_back(v); mCnt++;
    end
  endfunction

  task automatic applyStimulus(input vec_t v);
    iRst_n = v.rstN; iMemBusy = v.busy; iMdDone = v.mdDone; iBranchTaken = v.taken;
    iOpClass = v.op; iWbSel = v.wbIn; iAluBSel = v.aluIn;
    #3;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    logic [6+2*SW+2+CW-1:0] act, exp;
    exp = {v.strb, v.wbSel, v.aluSel, v.selErr, v.fault, CW'(v.cnt)};
    act = {oPcWrite, oIrWrite, oMemRead, oMemWrite, oRegWrite, oMdStart,
           oWbSel, oAluBSel, oSelErr, oFault, oRetireCnt};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got {strb,wb,alu,err,flt,cnt}=%h expected %h",
               tag, $time, act, exp);
    end
  endtask

  task automatic runQueue(input string tag);
    vec_t v;
    while (expQ.size() > 0) begin
      v = expQ.pop_front();
      applyStimulus(v);
      checkOutput(v, tag);
      @(posedge iClk); #1;
    end
  endtask

  initial begin
    vec_t v;
    int op, fb, mb, md;
    logic [SW-1:0] wb, alu;

    // The directed table covers the third reset cycle, the single IDLE cycle,
    // and an unstalled ALU_R instruction, followed by the first cycle of the
    // next (stalled) FETCH.
    dirTab[0] = dv(1'b0, 1'b0, 3'd0, 8'h01, 8'h01, 6'b000000, 8'h01, 8'h01, 0);
    dirTab[1] = dv(1'b1, 1'b0, 3'd0, 8'h01, 8'h01, 6'b000000, 8'h01, 8'h01, 0);
    dirTab[2] = dv(1'b1, 1'b0, 3'd5, 8'h80, 8'h40, 6'b111000, 8'h01, 8'h08, 0);
    dirTab[3] = dv(1'b1, 1'b0, 3'd0, 8'h01, 8'h01, 6'b000000, 8'h01, 8'h01, 0);
    dirTab[4] = dv(1'b1, 1'b1, 3'd3, 8'h10, 8'h20, 6'b000000, 8'h01, 8'h01, 0);
    dirTab[5] = dv(1'b1, 1'b1, 3'd2, 8'h04, 8'h04, 6'b000010, 8'h01, 8'h01, 0);
    dirTab[6] = dv(1'b1, 1'b1, 3'd0, 8'h01, 8'h01, 6'b001000, 8'h01, 8'h08, 1);

    iRst_n = 1'b0; iOpClass = '0; iWbSel = 8'h01; iAluBSel = 8'h01;
    iBranchTaken = 1'b0; iMemBusy = 1'b0; iMdDone = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(dirTab[i]);
      checkOutput(dirTab[i], $sformatf("dirTab[%0d]", i));
      @(posedge iClk); #1;
    end
    mCnt = 1;

    // LOAD stalled 2 cycles in MEM, writing back from source bit1.
    buildInstr(2, 8'h02, 8'h01, 0, 2, 0, 1'b0);
    runQueue("load_mem_busy");
    // BRANCH not taken: no PC write, retires straight back to FETCH.
    buildInstr(4, 8'h01, 8'h04, 0, 0, 0, 1'b0);
    runQueue("branch_not_taken");
    // Multi-hot write-back select: sticky error, bit0 used in WB.
    buildInstr(0, 8'h06, 8'h01, 1, 0, 0, 1'b0);
    buildInstr(1, 8'h01, 8'h01, 0, 0, 0, 1'b0);
    runQueue("sel_error");

    // Reset during a FETCH that would otherwise strobe. This aborts the
    // instruction and clears the sticky flags and the counter.
    v = cyc(); v.rstN = 1'b0; v.busy = 1'b0; expQ.push_back(v);
    mCnt = 0; mSelErr = 1'b0; mFault = 1'b0;
    v = cyc(); expQ.push_back(v);
    buildInstr(5, 8'h01, 8'h01, 0, 0, 0, 1'b0);
    buildInstr(3, 8'h01, 8'h02, 0, 1, 0, 1'b0);
    runQueue("mid_reset");

`ifdef MCSEQ_WDOG_EN
    // Watchdog trips after WL silent MDWAIT cycles; iMdDone on the limit
    // cycle still wins.
    buildInstr(6, 8'h04, 8'h02, 0, 0, -1, 1'b0);
    buildInstr(0, 8'h01, 8'h01, 0, 0, 0, 1'b0);
    buildInstr(6, 8'h08, 8'h02, 0, 0, WL - 1, 1'b0);
    runQueue("watchdog");
`endif

    // Randomized instruction stream checked cycle-by-cycle against the model.
    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(7, 0);
      wb  = ($urandom_range(3, 0) != 0) ? SW'(1) << $urandom_range(SW - 1, 0) : SW'($urandom);
      alu = ($urandom_range(3, 0) != 0) ? SW'(1) << $urandom_range(SW - 1, 0) : SW'($urandom);
      fb = $urandom_range(2, 0);
      mb = $urandom_range(2, 0);
`ifdef MCSEQ_WDOG_EN
      md = $urandom_range(WL - 1, 0);
`else
      md = $urandom_range(5, 0);
`endif
      buildInstr(op, wb, alu, fb, mb, md, 1'($urandom));
      runQueue("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
